// File: rtl/ll_seizure_detector.sv
// ll_seizure_detector
// Consumes line-length feature samples and declares seizure onset/offset
// with hysteresis (separate on/off thresholds) and minimum-duration
// qualification, followed by an optional holdoff before re-arming.
// All outputs are registered; onset/offset are single-cycle pulses.

module ll_seizure_detector #(
    parameter int data_width = 32,
    parameter int ON_CNT     = 4,
    parameter int OFF_CNT    = 8,
    parameter int HOLDOFF    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [data_width-1:0] din,
    input  logic signed [data_width-1:0] thr_on,
    input  logic signed [data_width-1:0] thr_off,
    output logic                         detect,
    output logic                         onset,
    output logic                         offset,
    output logic [CNT_W-1:0]             event_cnt,
    output logic [1:0]                   state_o
);

    // One counter width covers the run, quiet and holdoff counters, so
    // none of them can ever wrap.
    localparam int MAX_AB  = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
    localparam int MAX_ALL = (MAX_AB > HOLDOFF) ? MAX_AB : HOLDOFF;
    localparam int CW      = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] ON_LIM   = CW'(ON_CNT);
    localparam logic [CW-1:0] OFF_LIM  = CW'(OFF_CNT);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLDOFF);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_DETECT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   on_cnt;
    logic [CW-1:0]   off_cnt;
    logic [CW-1:0]   hold_cnt;
    logic            above;
    logic            below;

    // Both compares are signed and strict; samples in between the two
    // thresholds form the hysteresis band.
    assign above   = (din > thr_on);
    assign below   = (din < thr_off);
    assign state_o = state;

    // Detection FSM with registered flag, pulses and saturating event count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            on_cnt    <= '0;
            off_cnt   <= '0;
            hold_cnt  <= '0;
            detect    <= 1'b0;
            onset     <= 1'b0;
            offset    <= 1'b0;
            event_cnt <= '0;
        end else begin
            onset  <= 1'b0;
            offset <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        if (above) begin
                            if (ON_CNT == 1) begin
                                state   <= ST_DETECT;
                                detect  <= 1'b1;
                                onset   <= 1'b1;
                                on_cnt  <= '0;
                                off_cnt <= '0;
                                if (event_cnt != {CNT_W{1'b1}}) begin
                                    event_cnt <= event_cnt + 1'b1;
                                end
                            end else begin
                                on_cnt <= {{(CW-1){1'b0}}, 1'b1};
                                state  <= ST_ARMING;
                            end
                        end
                    end

                    ST_ARMING: begin
                        if (above) begin
                            if (on_cnt == ON_LIM - 1'b1) begin
                                state   <= ST_DETECT;
                                detect  <= 1'b1;
                                onset   <= 1'b1;
                                on_cnt  <= '0;
                                off_cnt <= '0;
                                if (event_cnt != {CNT_W{1'b1}}) begin
                                    event_cnt <= event_cnt + 1'b1;
                                end
                            end else begin
                                on_cnt <= on_cnt + 1'b1;
                            end
                        end else begin
                            on_cnt <= '0;
                            state  <= ST_IDLE;
                        end
                    end

                    ST_DETECT: begin
                        if (below) begin
                            if (off_cnt == OFF_LIM - 1'b1) begin
                                detect   <= 1'b0;
                                offset   <= 1'b1;
                                off_cnt  <= '0;
                                hold_cnt <= HOLD_LIM;
                                if (HOLDOFF == 0) begin
                                    state <= ST_IDLE;
                                end else begin
                                    state <= ST_HOLDOFF;
                                end
                            end else begin
                                off_cnt <= off_cnt + 1'b1;
                            end
                        end else begin
                            off_cnt <= '0;
                        end
                    end

                    ST_HOLDOFF: begin
                        if (hold_cnt <= {{(CW-1){1'b0}}, 1'b1}) begin
                            hold_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
